// File: rtl/key_event_rx_pio_pkg.sv
// Register map constants and bit positions for the key-event receive PIO.
package key_event_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_STATUS   = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;

    localparam int unsigned DATA_VALID_BIT   = 8;

    localparam int unsigned STATUS_EMPTY_BIT = 0;
    localparam int unsigned STATUS_FULL_BIT  = 1;
    localparam int unsigned STATUS_OVF_BIT   = 2;
    localparam int unsigned STATUS_LEVEL_LSB = 8;

    localparam int unsigned MASK_DATA_BIT    = 0;
    localparam int unsigned MASK_OVF_BIT     = 1;

endpackage

// File: rtl/key_event_rx_pio_if.sv
// Avalon-MM slave bus bundle used by the key-event receive PIO.
interface key_event_rx_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, read_n, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, read_n, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/key_event_rx_pio_fifo.sv
// Synchronous FIFO holding pushed key codes; head is the oldest entry.
module key_event_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         data,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/key_event_rx_pio.sv
// Avalon-MM receive PIO: hardware pushes key codes, CPU pops them via DATA reads.
module key_event_rx_pio
    import key_event_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    key_event_rx_pio_if.slave    bus,
    output logic                 irq,
    input  logic [WIDTH-1:0]     in_code,
    input  logic                 in_valid,
    output logic                 in_ready
);
    logic [WIDTH-1:0]       head;
    logic                   empty;
    logic                   full;
    logic [$clog2(DEPTH):0] level;
    logic                   overflow;
    logic [1:0]             irq_mask;
    logic                   rd_en;
    logic                   wr_en;
    logic                   pop;
    logic                   push;
    logic                   drop;
    logic                   unused_wdata;

    assign rd_en    = bus.chipselect && !bus.read_n;
    assign wr_en    = bus.chipselect && !bus.write_n;
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign drop     = in_valid && !in_ready;
    assign pop      = rd_en && (bus.address == ADDR_DATA) && !empty;
    assign unused_wdata = ^bus.writedata[31:3];

    key_event_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .data    (in_code),
        .head    (head),
        .empty   (empty),
        .full    (full),
        .level   (level)
    );

    // A drop in the same cycle as a CPU clear leaves overflow set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
            irq_mask <= '0;
        end else begin
            if (drop)
                overflow <= 1'b1;
            else if (wr_en && bus.address == ADDR_STATUS && bus.writedata[STATUS_OVF_BIT])
                overflow <= 1'b0;
            if (wr_en && bus.address == ADDR_IRQ_MASK)
                irq_mask <= bus.writedata[1:0];
        end
    end

    assign irq = (irq_mask[MASK_DATA_BIT] && !empty) || (irq_mask[MASK_OVF_BIT] && overflow);

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA: begin
                if (!empty) begin
                    bus.readdata[WIDTH-1:0]      = head;
                    bus.readdata[DATA_VALID_BIT] = 1'b1;
                end
            end
            ADDR_STATUS: begin
                bus.readdata[STATUS_EMPTY_BIT]                  = empty;
                bus.readdata[STATUS_FULL_BIT]                   = full;
                bus.readdata[STATUS_OVF_BIT]                    = overflow;
                bus.readdata[STATUS_LEVEL_LSB +: 8]             = 8'(level);
            end
            ADDR_IRQ_MASK: bus.readdata[1:0] = irq_mask;
            default:       bus.readdata = '0;
        endcase
    end
endmodule

// File: tb/tb_key_event_rx_pio.sv
// Self-checking bench: directed table, hand sequences, and random traffic vs a queue model.
module tb_key_event_rx_pio;
    localparam int DEPTH = 8;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [WIDTH-1:0] in_code = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             irq;

    key_event_rx_pio_if bus ();

    key_event_rx_pio #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus.slave),
        .irq      (irq),
        .in_code  (in_code),
        .in_valid (in_valid),
        .in_ready (in_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural reference: a queue of pending codes plus two flag registers.
    int unsigned q[$];
    bit          m_ovf;
    bit [1:0]    m_mask;

    logic [31:0] s_rd;
    logic        s_irq;
    logic        s_ready;

    typedef struct {
        bit        v;
        bit [7:0]  code;
        bit        rd;
        bit        wr;
        bit [1:0]  addr;
        bit [31:0] wdata;
        bit [31:0] exp_rd;
        bit        exp_irq;
        bit        exp_ready;
    } vec_t;

    function automatic bit [31:0] model_rd(input bit [1:0] addr);
        bit [31:0] r;
        r = 0;
        case (addr)
            2'd0: if (q.size() > 0) r = 32'h100 | q[0];
            2'd1: r = (q.size() << 8) | (32'(m_ovf) << 2)
                      | (32'(q.size() == DEPTH) << 1) | 32'(q.size() == 0);
            2'd2: r = {30'd0, m_mask};
            default: r = 0;
        endcase
        return r;
    endfunction

    function automatic bit model_irq();
        return (m_mask[0] && q.size() > 0) || (m_mask[1] && m_ovf);
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf  = 0;
        m_mask = 0;
    endtask

    // One bus/stream cycle: drive after negedge, compare against model, advance model.
    task automatic cycle(input bit v, input bit [7:0] code, input bit rd, input bit wr,
                         input bit [1:0] addr, input bit [31:0] wdata);
        bit full, drop;
        @(negedge clk);
        in_valid       = v;
        in_code        = code;
        bus.chipselect = rd | wr;
        bus.read_n     = !rd;
        bus.write_n    = !wr;
        bus.address    = addr;
        bus.writedata  = wdata;
        #1;
        s_rd    = bus.readdata;
        s_irq   = irq;
        s_ready = in_ready;
        check32("model_readdata", s_rd, rd ? model_rd(addr) : s_rd);
        check32("model_irq", {31'd0, s_irq}, {31'd0, model_irq()});
        full = (q.size() == DEPTH);
        check32("model_in_ready", {31'd0, s_ready}, {31'd0, !full});
        if (!rd) check32("model_readdata_idle", s_rd, model_rd(addr));
        drop = v && full;
        if (rd && addr == 0 && q.size() > 0) void'(q.pop_front());
        if (v && !full) q.push_back(code);
        if (drop) m_ovf = 1;
        else if (wr && addr == 1 && wdata[2]) m_ovf = 0;
        if (wr && addr == 2) m_mask = wdata[1:0];
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 1, 0);
    endtask

    vec_t tbl[$];

    initial begin
        bus.chipselect = 0; bus.read_n = 1; bus.write_n = 1;
        bus.address = 0; bus.writedata = 0;
        model_reset();

        //          v code  rd wr a  wdata   exp_rd        irq rdy
        tbl.push_back('{0, 8'h00, 1, 0, 1, 0, 32'h00000001, 0, 1});
        tbl.push_back('{0, 8'h00, 1, 0, 0, 0, 32'h00000000, 0, 1});
        tbl.push_back('{1, 8'h1C, 1, 0, 1, 0, 32'h00000001, 0, 1});
        tbl.push_back('{1, 8'h32, 1, 0, 1, 0, 32'h00000100, 0, 1});
        tbl.push_back('{1, 8'h23, 1, 0, 1, 0, 32'h00000200, 0, 1});
        tbl.push_back('{0, 8'h00, 1, 0, 1, 0, 32'h00000300, 0, 1});
        tbl.push_back('{0, 8'h00, 1, 0, 0, 0, 32'h0000011C, 0, 1});
        tbl.push_back('{0, 8'h00, 1, 0, 0, 0, 32'h00000132, 0, 1});
        tbl.push_back('{0, 8'h00, 1, 0, 0, 0, 32'h00000123, 0, 1});
        tbl.push_back('{0, 8'h00, 1, 0, 0, 0, 32'h00000000, 0, 1});
        tbl.push_back('{0, 8'h00, 1, 0, 1, 0, 32'h00000001, 0, 1});
        tbl.push_back('{0, 8'h00, 1, 0, 3, 0, 32'h00000000, 0, 1});
        tbl.push_back('{0, 8'h00, 0, 1, 0, 32'hFF, 32'h00000000, 0, 1});
        tbl.push_back('{0, 8'h00, 1, 0, 0, 0, 32'h00000000, 0, 1});

        repeat (2) @(negedge clk);
        reset_n = 1;

        foreach (tbl[i]) begin
            cycle(tbl[i].v, tbl[i].code, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
            check32($sformatf("tbl%0d_readdata", i), s_rd, tbl[i].exp_rd);
            check32($sformatf("tbl%0d_irq", i), {31'd0, s_irq}, {31'd0, tbl[i].exp_irq});
            check32($sformatf("tbl%0d_ready", i), {31'd0, s_ready}, {31'd0, tbl[i].exp_ready});
        end

        // Fill past capacity: 0x09 must be dropped.
        for (int k = 1; k <= 9; k++) begin
            cycle(1, 8'(k), 0, 0, 1, 0);
            if (k == 9) check32("fill_ready_after_8", {31'd0, s_ready}, 32'd0);
        end
        cycle(0, 0, 1, 0, 1, 0);
        check32("fill_status", s_rd, 32'h00000806);
        for (int k = 1; k <= 8; k++) begin
            cycle(0, 0, 1, 0, 0, 0);
            check32($sformatf("drain_%0d", k), s_rd, 32'h100 | 32'(k));
        end
        cycle(0, 0, 1, 0, 0, 0);
        check32("drain_empty", s_rd, 32'h0);

        // Full with simultaneous pop and push.
        cycle(0, 0, 0, 1, 1, 32'h4);
        for (int k = 0; k < 8; k++) cycle(1, 8'h60 + 8'(k), 0, 0, 1, 0);
        cycle(1, 8'h55, 1, 0, 0, 0);
        check32("fullpop_head", s_rd, 32'h160);
        check32("fullpop_ready", {31'd0, s_ready}, 32'd0);
        cycle(0, 0, 1, 0, 1, 0);
        check32("fullpop_status", s_rd, 32'h00000704);
        cycle(0, 0, 0, 1, 1, 32'h4);
        cycle(0, 0, 1, 0, 1, 0);
        check32("ovf_cleared", s_rd, 32'h00000700);
        for (int k = 1; k < 8; k++) cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        check32("no_55_seen", s_rd, 32'h0);

        // Overflow set beats CPU clear in the same cycle.
        for (int k = 0; k < 8; k++) cycle(1, 8'(k), 0, 0, 1, 0);
        cycle(1, 8'hEE, 0, 1, 1, 32'h4);
        cycle(0, 0, 1, 0, 1, 0);
        check32("set_beats_clear", s_rd, 32'h00000806);
        cycle(0, 0, 0, 1, 1, 32'h4);
        for (int k = 0; k < 8; k++) cycle(0, 0, 1, 0, 0, 0);

        // IRQ behaviour.
        cycle(0, 0, 0, 1, 2, 32'h1);
        cycle(1, 8'hAA, 0, 0, 1, 0);
        check32("irq_before_push", {31'd0, s_irq}, 32'd0);
        cycle(0, 0, 1, 0, 0, 0);
        check32("irq_data_pending", {31'd0, s_irq}, 32'd1);
        check32("irq_read_aa", s_rd, 32'h1AA);
        idle();
        check32("irq_after_pop", {31'd0, s_irq}, 32'd0);
        cycle(0, 0, 0, 1, 2, 32'h2);
        for (int k = 0; k < 9; k++) cycle(1, 8'(k), 0, 0, 1, 0);
        idle();
        check32("irq_overflow", {31'd0, s_irq}, 32'd1);
        cycle(0, 0, 0, 1, 1, 32'h4);
        check32("irq_ovf_before_clear", {31'd0, s_irq}, 32'd1);
        idle();
        check32("irq_ovf_cleared", {31'd0, s_irq}, 32'd0);
        cycle(0, 0, 1, 0, 2, 0);
        check32("mask_readback", s_rd, 32'h2);

        // Asynchronous reset mid-stream.
        for (int k = 0; k < 4; k++) cycle(1, 8'h40 + 8'(k), 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 2, 32'h3);
        @(negedge clk);
        in_valid = 0; bus.chipselect = 1; bus.read_n = 0; bus.write_n = 1; bus.address = 1;
        #1 reset_n = 0;
        #1;
        check32("reset_status", bus.readdata, 32'h00000001);
        check32("reset_irq", {31'd0, irq}, 32'd0);
        check32("reset_ready", {31'd0, in_ready}, 32'd1);
        reset_n = 1;
        model_reset();
        cycle(0, 0, 1, 0, 0, 0);
        check32("reset_no_stale", s_rd, 32'h0);
        cycle(0, 0, 1, 0, 2, 0);
        check32("reset_mask", s_rd, 32'h0);

        // Random traffic against the queue model.
        for (int n = 0; n < 1500; n++) begin
            bit v, rd, wr;
            bit [1:0] a;
            bit [31:0] wd;
            v  = ($urandom_range(0, 99) < 55);
            rd = ($urandom_range(0, 99) < 45);
            wr = !rd && ($urandom_range(0, 99) < 20);
            a  = 2'($urandom_range(0, 3));
            wd = $urandom;
            cycle(v, 8'($urandom), rd, wr, a, wd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
